mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single memory port of the simulation RAM between up to `N_REQ` requesters (e.g. several harts or a core plus a bench loader). One access is in flight at a time. Each access is range-checked against the RAM window, forwarded to the memory port, and answered with a one-cycle response pulse to the requester that owned it. It sits between the requester bus adapters and the RAM's memory-side interface.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared RAM port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_SIZE   = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [N_REQ-1:0]                 req_valid_i;
    logic [N_REQ-1:0]                 req_ready_o;
    logic [N_REQ-1:0]                 req_we_i;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
    logic [N_REQ-1:0][STRB_WIDTH-1:0] req_wstrb_i;
    logic [N_REQ-1:0]                 rsp_valid_o;
    logic                             rsp_err_o;
    logic [DATA_WIDTH-1:0]            rsp_rdata_o;
    logic                             mem_req_o;
    logic                             mem_we_o;
    logic [MEM_SIZE-1:0]              mem_addr_o;
    logic [DATA_WIDTH-1:0]            mem_wdata_o;
    logic [STRB_WIDTH-1:0]            mem_wstrb_o;
    logic [DATA_WIDTH-1:0]            mem_rdata_i;
    logic                             busy_o;

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, busy_o
    );

    // Requesters plus RAM, as seen from the environment.
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among N_REQ requesters,
// one range-checked access in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned          N_REQ       = 4,
    parameter int unsigned          ADDR_WIDTH  = 64,
    parameter int unsigned          DATA_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
    parameter int unsigned          MEM_SIZE    = 32,
    parameter int unsigned          MEM_LATENCY = 1
) (
    input logic                clk_i,
    input logic                rst_ni,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W      = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    // Upper bound evaluated one bit wider so a window at the top of the space cannot wrap.
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT =
        {1'b0, MEM_BASE} + ((ADDR_WIDTH+1)'(1) << MEM_SIZE);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       last_q;
    logic [IDX_W-1:0]       owner_q;
    logic                   we_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [MEM_SIZE-1:0]    mem_addr_q;
    logic [DATA_WIDTH-1:0]  mem_wdata_q;
    logic [STRB_WIDTH-1:0]  mem_wstrb_q;
    logic [N_REQ-1:0]       rsp_valid_q;
    logic                   rsp_err_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;

    logic [IDX_W-1:0]       winner;
    logic                   found;
    int unsigned            cand;

    // Rotating search starting just after the last grant.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = 32'(last_q) + off;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && bus.req_valid_i[IDX_W'(cand)]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_wstrb;
    logic                  in_range;

    assign accept    = (state_q == ST_IDLE) && found;
    assign sel_we    = bus.req_we_i[winner];
    assign sel_addr  = bus.req_addr_i[winner];
    assign sel_wdata = bus.req_wdata_i[winner];
    assign sel_wstrb = bus.req_wstrb_i[winner];
    assign in_range  = (sel_addr >= MEM_BASE) && ({1'b0, sel_addr} < MEM_LIMIT);

    assign bus.req_ready_o = {N_REQ{accept}} & (N_REQ'(1) << winner);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_wstrb_o = mem_wstrb_q;
    assign bus.busy_o      = busy_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            last_q      <= IDX_W'(N_REQ - 1);
            owner_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        last_q  <= winner;
                        owner_q <= winner;
                        we_q    <= sel_we;
                        busy_q  <= 1'b1;
                        if (in_range) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= sel_we;
                            mem_addr_q  <= MEM_SIZE'(sel_addr - MEM_BASE);
                            mem_wdata_q <= sel_wdata;
                            mem_wstrb_q <= sel_wstrb;
                            state_q     <= ST_ISSUE;
                        end else begin
                            rsp_valid_q <= N_REQ'(1) << winner;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_wstrb_q <= '0;
                    // The ISSUE cycle itself is the first latency cycle.
                    if (MEM_LATENCY <= 1) begin
                        rsp_valid_q <= N_REQ'(1) << owner_q;
                        rsp_rdata_q <= we_q ? '0 : bus.mem_rdata_i;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q   <= CNT_W'(MEM_LATENCY - 2);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= N_REQ'(1) << owner_q;
                        rsp_rdata_q <= we_q ? '0 : bus.mem_rdata_i;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= '0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: latency-1 and latency-3 instances
// share stimulus and are each checked against a transaction-timeline model.
module tb_mem_port_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned MS = 32;
    localparam logic [AW-1:0] BASE = '0;

    localparam int M_RESET = 0, M_IDLE = 1, M_SINGLE = 2, M_RR = 3, M_WRITE = 4,
                   M_OOR = 5, M_RSTMID = 6, M_RAND = 7, M_RST = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [N-1:0]           v, we;
    logic [N-1:0][AW-1:0]   addr;
    logic [N-1:0][DW-1:0]   wd;
    logic [N-1:0][SW-1:0]   ws;
    logic [DW-1:0]          mrd;

    mem_port_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) bus1 ();
    mem_port_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) bus3 ();

    assign bus1.req_valid_i = v;    assign bus3.req_valid_i = v;
    assign bus1.req_we_i    = we;   assign bus3.req_we_i    = we;
    assign bus1.req_addr_i  = addr; assign bus3.req_addr_i  = addr;
    assign bus1.req_wdata_i = wd;   assign bus3.req_wdata_i = wd;
    assign bus1.req_wstrb_i = ws;   assign bus3.req_wstrb_i = ws;
    assign bus1.mem_rdata_i = mrd;  assign bus3.mem_rdata_i = mrd;

    mem_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BASE(BASE),
                       .MEM_SIZE(MS), .MEM_LATENCY(1))
        dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));
    mem_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BASE(BASE),
                       .MEM_SIZE(MS), .MEM_LATENCY(3))
        dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(bus3.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Per-instance model: when the port is free again, plus the one scheduled access.
    int              lat [2] = '{1, 3};
    int              nxt [2], acc [2], mem_c [2], samp_c [2], rsp_c [2];
    int              last [2], own [2];
    bit              e_we [2], e_err [2];
    logic [MS-1:0]   e_addr [2];
    logic [DW-1:0]   e_wd [2], e_rd [2];
    logic [SW-1:0]   e_ws [2];

    task automatic reset_model(input int k, input int c);
        nxt[k] = c + 1; acc[k] = c; last[k] = N - 1;
        mem_c[k] = -1; samp_c[k] = -1; rsp_c[k] = -1;
    endtask

    function automatic bit in_window(input logic [AW-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + (65'd1 << MS)));
    endfunction

    task automatic model_step(input int k);
        logic [N-1:0]  o_ready, o_rsp;
        logic          o_err, o_req, o_we, o_busy;
        logic [MS-1:0] o_addr;
        logic [DW-1:0] o_rd, o_wd;
        logic [SW-1:0] o_ws;
        int            win, c;
        bit            m_exp;
        string         p;
        c = cyc;
        p = $sformatf("L%0d", lat[k]);
        if (k == 0) begin
            o_ready = bus1.req_ready_o; o_rsp = bus1.rsp_valid_o; o_err = bus1.rsp_err_o;
            o_rd = bus1.rsp_rdata_o; o_req = bus1.mem_req_o; o_we = bus1.mem_we_o;
            o_addr = bus1.mem_addr_o; o_wd = bus1.mem_wdata_o; o_ws = bus1.mem_wstrb_o;
            o_busy = bus1.busy_o;
        end else begin
            o_ready = bus3.req_ready_o; o_rsp = bus3.rsp_valid_o; o_err = bus3.rsp_err_o;
            o_rd = bus3.rsp_rdata_o; o_req = bus3.mem_req_o; o_we = bus3.mem_we_o;
            o_addr = bus3.mem_addr_o; o_wd = bus3.mem_wdata_o; o_ws = bus3.mem_wstrb_o;
            o_busy = bus3.busy_o;
        end
        if (c == samp_c[k]) e_rd[k] = e_we[k] ? '0 : mrd;
        win = -1;
        if (c >= nxt[k])
            for (int off = 1; off <= N; off++)
                if (win < 0 && v[(last[k] + off) % N]) win = (last[k] + off) % N;

        check_val({p, " ready"}, 64'(o_ready), (win >= 0) ? 64'(1) << win : 64'd0);
        check_val({p, " busy"}, 64'(o_busy), 64'((c > acc[k]) && (c < nxt[k])));
        m_exp = (c == mem_c[k]);
        check_val({p, " mem_req"}, 64'(o_req), 64'(m_exp));
        check_val({p, " mem_we"}, 64'(o_we), m_exp ? 64'(e_we[k]) : 64'd0);
        check_val({p, " mem_addr"}, 64'(o_addr), m_exp ? 64'(e_addr[k]) : 64'd0);
        check_val({p, " mem_wdata"}, o_wd, m_exp ? e_wd[k] : 64'd0);
        check_val({p, " mem_wstrb"}, 64'(o_ws), m_exp ? 64'(e_ws[k]) : 64'd0);
        check_val({p, " rsp_valid"}, 64'(o_rsp), (c == rsp_c[k]) ? 64'(1) << own[k] : 64'd0);
        if (c == rsp_c[k]) begin
            check_val({p, " rsp_err"}, 64'(o_err), 64'(e_err[k]));
            check_val({p, " rsp_rdata"}, o_rd, e_rd[k]);
        end

        if (!rst_n) begin
            reset_model(k, c);
        end else if (win >= 0) begin
            last[k] = win; own[k] = win; acc[k] = c; e_we[k] = we[win];
            if (in_window(addr[win])) begin
                e_err[k] = 1'b0; e_addr[k] = MS'(addr[win] - BASE);
                e_wd[k] = wd[win]; e_ws[k] = ws[win];
                mem_c[k] = c + 1; samp_c[k] = c + lat[k];
                rsp_c[k] = c + lat[k] + 1; nxt[k] = c + lat[k] + 2;
            end else begin
                e_err[k] = 1'b1; e_rd[k] = '0;
                mem_c[k] = -1; samp_c[k] = -1;
                rsp_c[k] = c + 1; nxt[k] = c + 2;
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 64'h1_0000_0000;
            1:       return 64'h0000_0000_FFFF_FFF8;
            2:       return {32'($urandom), 32'($urandom)};
            default: return {32'h0, 32'($urandom) & 32'hFFFF_FFF8};
        endcase
    endfunction

    task automatic drive(input int mode, input int j);
        rst_n = 1'b1; v = '0; we = '0; addr = '0; wd = '0; ws = '0;
        mrd = {32'($urandom), 32'($urandom)};
        case (mode)
            M_RESET: rst_n = 1'b0;
            M_SINGLE: begin
                mrd = 64'hDEADBEEF_CAFEF00D;
                if (j == 0) begin v[2] = 1'b1; addr[2] = 64'h100; end
            end
            M_RR: begin
                v = '1;
                for (int i = 0; i < N; i++) addr[i] = 64'(i * 64 + j * 8);
            end
            M_WRITE: if (j == 0) begin
                v[1] = 1'b1; we[1] = 1'b1; addr[1] = 64'h8;
                wd[1] = 64'h11223344_55667788; ws[1] = 8'h0F;
            end
            M_OOR: if (j == 0) begin v[0] = 1'b1; addr[0] = 64'h1_0000_0000; end
            M_RSTMID: begin
                v = 4'b1001;
                addr[0] = 64'h40; addr[3] = 64'h80;
                if (j == 3) rst_n = 1'b0;
            end
            M_RAND, M_RST: begin
                if (mode == M_RST && $urandom_range(0, 15) == 0) rst_n = 1'b0;
                v = N'($urandom);
                for (int i = 0; i < N; i++) begin
                    we[i] = 1'($urandom); addr[i] = rand_addr();
                    wd[i] = {32'($urandom), 32'($urandom)}; ws[i] = SW'($urandom);
                end
            end
            default: ;
        endcase
    endtask

    task automatic run(input int mode, input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            drive(mode, j);
            @(negedge clk);
            model_step(0);
            model_step(1);
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0; v = '0; we = '0; addr = '0; wd = '0; ws = '0; mrd = '0;
        reset_model(0, -1);
        reset_model(1, -1);
        run(M_RESET, 2);
        run(M_SINGLE, 6);
        run(M_IDLE, 2);
        run(M_RESET, 1);
        run(M_RR, 20);
        run(M_IDLE, 6);
        run(M_WRITE, 6);
        run(M_OOR, 4);
        run(M_IDLE, 6);
        run(M_RSTMID, 10);
        run(M_RAND, 400);
        run(M_RST, 400);
        run(M_IDLE, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
